// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and the control units that drive it.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Next-PC select encodings produced by decode.
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_FOR    = 2'b11;

  // Control-transfer opcode/func fields (opcode = instr[15:12], func = instr[2:0]).
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [2:0] FUNC_JMP  = 3'b000;
  localparam logic [2:0] FUNC_CALL = 3'b001;
  localparam logic [2:0] FUNC_RET  = 3'b010;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection, including the return-address (RR) path.
module pc_next_mux
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = fetch_stage_pkg::ADDR_W
) (
  input  logic [1:0]        pc_src,
  input  logic              jump_src,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] rr,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] for_target,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] next_pc
);

  localparam logic [ADDR_W-1:0] One = 1;

  // Sequential increment wraps modulo 2^ADDR_W with no overflow flag.
  assign pc_plus1 = pc + One;

  // Select the PC for the next fetch; jump_src picks RR for Ret.
  always_comb begin
    next_pc = pc_plus1;
    unique case (pc_src)
      PCSRC_SEQ:    next_pc = pc_plus1;
      PCSRC_BRANCH: next_pc = branch_target;
      PCSRC_JUMP:   next_pc = jump_src ? rr : jump_target;
      PCSRC_FOR:    next_pc = for_target;
      default:      next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, return-address register and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned          INSTR_W   = fetch_stage_pkg::INSTR_W,
  parameter int unsigned          ADDR_W    = fetch_stage_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               kill,
  input  logic [1:0]         pc_src,
  input  logic               jump_src,
  input  logic               rrwe,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [ADDR_W-1:0]  for_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_plus1,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  rr_value
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rr_q, rr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [ADDR_W-1:0]  ipc1_q, ipc1_d;
  logic               valid_q, valid_d;

  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  next_pc;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .pc_src        (pc_src),
    .jump_src      (jump_src),
    .pc            (pc_q),
    .rr            (rr_q),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .for_target    (for_target),
    .pc_plus1      (pc_plus1),
    .next_pc       (next_pc)
  );

  // Next-state: stall freezes everything and masks kill/pc_src/rrwe.
  always_comb begin
    pc_d    = pc_q;
    rr_d    = rr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    valid_d = valid_q;
    if (!stall) begin
      pc_d = next_pc;
      if (kill) begin
        instr_d = NOP_INSTR;
        ipc_d   = '0;
        ipc1_d  = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        ipc1_d  = pc_plus1;
        valid_d = 1'b1;
      end
      // Return address of the Call currently in decode.
      if (rrwe) begin
        rr_d = ipc1_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      rr_q    <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      ipc1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rr_q    <= rr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus1 = ipc1_q;
  assign if_id_valid    = valid_q;
  assign rr_value       = rr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, a behavioural model and
// a negedge compare process, plus hand-computed literal checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, kill, jump_src, rrwe;
  logic [1:0]  pc_src;
  logic [15:0] branch_target, jump_target, for_target;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus1, rr_value;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state (reset values).
  logic [15:0] m_pc = 16'h0, m_rr = 16'h0, m_instr = 16'h0, m_ipc = 16'h0, m_ipc1 = 16'h0;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [15:0] instr_at(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  assign imem_rdata = instr_at(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .kill           (kill),
    .pc_src         (pc_src),
    .jump_src       (jump_src),
    .rrwe           (rrwe),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .for_target     (for_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .rr_value       (rr_value)
  );

  function automatic logic [15:0] model_next_pc();
    case (pc_src)
      2'd0:    return m_pc + 16'd1;
      2'd1:    return branch_target;
      2'd2:    return jump_src ? m_rr : jump_target;
      default: return for_target;
    endcase
  endfunction

  // Model: what the fetch stage must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 16'h0; m_rr <= 16'h0; m_instr <= 16'h0;
      m_ipc <= 16'h0; m_ipc1 <= 16'h0; m_valid <= 1'b0;
    end else if (!stall) begin
      m_pc <= model_next_pc();
      if (kill) begin
        m_instr <= 16'h0; m_ipc <= 16'h0; m_ipc1 <= 16'h0; m_valid <= 1'b0;
      end else begin
        m_instr <= instr_at(m_pc); m_ipc <= m_pc; m_ipc1 <= m_pc + 16'd1; m_valid <= 1'b1;
      end
      if (rrwe) m_rr <= m_ipc1;
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  // Compare process: DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_instr", if_id_instr, m_instr);
      chk("m_pc", if_id_pc, m_ipc);
      chk("m_pc1", if_id_pc_plus1, m_ipc1);
      chk("m_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
      chk("m_rr", rr_value, m_rr);
    end
  end

  task automatic idle();
    stall = 0; kill = 0; pc_src = 2'd0; jump_src = 0; rrwe = 0;
    branch_target = 16'h0; jump_target = 16'h0; for_target = 16'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mixed stall/kill/redirect vectors: {stall, kill, pc_src}
  logic [3:0] mix [0:7] = '{4'b0000, 4'b1000, 4'b0101, 4'b0000,
                            4'b1111, 4'b0000, 4'b0100, 4'b0011};

  initial begin
    idle();
    #1 rst_n = 1'b0;
    check_en = 1'b1;
    step(); step();
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
    chk("rst_rr", rr_value, 16'h0000);
    @(negedge clk) rst_n = 1'b1;

    // Sequential fetch of A, B, C.
    step(); chk("seq_a", if_id_instr, 16'h5A00); chk("seq_pc0", if_id_pc, 16'd0);
    step(); chk("seq_b", if_id_instr, 16'h5A01); chk("seq_pc1", if_id_pc, 16'd1);
    step(); chk("seq_c", if_id_instr, 16'h5A02); chk("seq_pc2", if_id_pc, 16'd2);
    chk("seq_valid", {15'd0, if_id_valid}, 16'd1);
    chk("seq_addr", imem_addr, 16'd3);
    step(); step();
    chk("pre_br_addr", imem_addr, 16'd5);

    // Taken branch from pc=5 to 20.
    pc_src = 2'd1; branch_target = 16'd20; kill = 1;
    step(); idle();
    chk("br_valid", {15'd0, if_id_valid}, 16'd0);
    chk("br_instr", if_id_instr, 16'h0000);
    chk("br_addr", imem_addr, 16'd20);
    step(); chk("br_ifpc", if_id_pc, 16'd20);

    // Get a Call into IF/ID at pc=8.
    pc_src = 2'd1; branch_target = 16'd8; kill = 1;
    step(); idle();
    step(); chk("call_ifpc", if_id_pc, 16'd8);
    rrwe = 1; pc_src = 2'd2; jump_src = 0; jump_target = 16'd40; kill = 1;
    step(); idle();
    chk("call_rr", rr_value, 16'd9);
    chk("call_addr", imem_addr, 16'd40);
    step();
    pc_src = 2'd2; jump_src = 1; kill = 1;
    step(); idle();
    chk("ret_addr", imem_addr, 16'd9);
    step(); step(); step();
    chk("pre_stall_addr", imem_addr, 16'd12);

    // Stall outranks kill, pc_src and rrwe.
    stall = 1; kill = 1; pc_src = 2'd1; branch_target = 16'd100; rrwe = 1;
    step(); step();
    chk("stall_addr", imem_addr, 16'd12);
    chk("stall_ifpc", if_id_pc, 16'd11);
    chk("stall_rr", rr_value, 16'd9);
    chk("stall_valid", {15'd0, if_id_valid}, 16'd1);
    idle();
    step();
    chk("unstall_ifpc", if_id_pc, 16'd12);
    chk("unstall_addr", imem_addr, 16'd13);

    // Wrap-around at all-ones.
    pc_src = 2'd3; for_target = 16'hFFFF; kill = 1;
    step(); idle();
    chk("wrap_pre", imem_addr, 16'hFFFF);
    step();
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_ifpc", if_id_pc, 16'hFFFF);
    chk("wrap_ifpc1", if_id_pc_plus1, 16'h0000);
    chk("wrap_instr", if_id_instr, 16'hA5FF);
    kill = 1;
    step(); idle();
    chk("kill_seq_valid", {15'd0, if_id_valid}, 16'd0);
    chk("kill_seq_addr", imem_addr, 16'd1);

    // Mixed vectors, checked by the model only.
    for (int i = 0; i < 8; i++) begin
      stall = mix[i][3]; kill = mix[i][2]; pc_src = mix[i][1:0];
      branch_target = 16'h0030 + 16'(i); jump_target = 16'h0050; for_target = 16'h0070;
      rrwe = i[0];
      step();
    end
    idle();
    step();

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 16'h0000);
    chk("arst_instr", if_id_instr, 16'h0000);
    chk("arst_pc", if_id_pc, 16'h0000);
    chk("arst_pc1", if_id_pc_plus1, 16'h0000);
    chk("arst_valid", {15'd0, if_id_valid}, 16'd0);
    chk("arst_rr", rr_value, 16'h0000);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post_arst_instr", if_id_instr, 16'h5A00);
    step();
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of decode.
- Consumes the PC-control outputs resolved in decode: kill, pc_src, jump_src and rrwe.
- Consumes the stall output of the forwarding/hazard unit.
- Holds the PC and the return-address register (RR), drives the instruction-memory address, and presents the fetched instruction with its PC to decode.

Parameters:
- INSTR_W, 16, instruction width; opcode is bits [15:12], func is bits [2:0].
- ADDR_W, 16, PC/instruction-address width. Memory is word-addressed: one instruction per address.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 16'h0000, encoding injected on kill or reset. The IF/ID valid bit marks it as a bubble.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  load-use hazard from the forwarding unit; freezes the PC and IF/ID.
- kill  in  1  flush of the instruction currently in fetch.
- pc_src  in  2  next-PC select. 00 = PC+1, 01 = branch target, 10 = jump, 11 = FOR target.
- jump_src  in  1  with pc_src=10: 0 = jump_target, 1 = RR (Ret).
- rrwe  in  1  Call in decode: write RR.
- branch_target  in  ADDR_W  BEQ/BNE target computed in decode.
- jump_target  in  ADDR_W  Jmp/Call target computed in decode.
- for_target  in  ADDR_W  FOR loop-back target computed in decode.
- imem_addr  out  ADDR_W  instruction-memory address; always equals the PC.
- imem_rdata  in  INSTR_W  instruction memory combinational read data.
- if_id_instr  out  INSTR_W  registered instruction to decode.
- if_id_pc  out  ADDR_W  registered PC of if_id_instr.
- if_id_pc_plus1  out  ADDR_W  registered if_id_pc+1.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- rr_value  out  ADDR_W  current return-address register.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - pc = RESET_PC; imem_addr therefore = RESET_PC while rst_n is low.
  - if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_pc_plus1 = 0, if_id_valid = 0, rr = 0.
- Reset mid-operation: immediately forces all state to its reset value regardless of stall or kill.
- First fetch after release: imem_addr = RESET_PC. The instruction appears on if_id_* after the first rising edge.
- Next-PC selection (combinational):
  - 00 = pc+1.
  - 01 = branch_target.
  - 10 = jump_src ? rr : jump_target.
  - 11 = for_target.
- Arithmetic is modulo 2^ADDR_W: pc = all-ones gives pc+1 = 0, with no flag.
- Latency: one cycle from imem_addr to if_id_instr.
- Redirect penalty: one bubble per taken control transfer.
- On a rising edge with stall=0:
  - pc <= next PC.
  - If kill=1: if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc and if_id_pc_plus1 <= 0.
  - Else: if_id_instr <= imem_rdata, if_id_pc <= pc, if_id_pc_plus1 <= pc+1, if_id_valid <= 1.
  - If rrwe=1: rr <= if_id_pc_plus1, the return address of the Call in decode.
- On a rising edge with stall=1: pc, all IF/ID registers and rr hold. kill, pc_src and rrwe are ignored that cycle; decode re-evaluates them on the next unstalled cycle.
- Simultaneous rrwe=1 with pc_src=10 and jump_src=1: next PC uses the old rr, and rr updates at the same edge. Decode never produces this combination; the behaviour is still defined.
- kill=1 with pc_src=00: bubble inserted, PC advances normally. This is legal, not an error.
- No internal state machine beyond the registers. The valid bit is the only pipeline-occupancy state.

Decomposition:
- Shared package:
  - PCSRC_SEQ = 2'b00, PCSRC_BRANCH = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_FOR = 2'b11.
  - NOP_INSTR, INSTR_W, ADDR_W.
  - Opcode/func constants for Jmp/Call/Ret, also used by the control units.
- One sub-module, pc_next_mux: combinational next-PC selection including the RR path.
- PC, RR and IF/ID registers stay in fetch_stage.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: hold rst_n=0, release, then three clocks with imem[0..2] = A, B, C.
  - Response: if_id_instr = A, B, C; if_id_pc = 0, 1, 2; if_id_valid = 1; imem_addr = 3.
- Taken branch:
  - Stimulus: with pc=5, drive pc_src=01, branch_target=20, kill=1 for one cycle.
  - Response: if_id_valid = 0 and if_id_instr = 16'h0000 next cycle; imem_addr = 20; the following cycle if_id_pc = 20.
- Call/Ret:
  - Stimulus: Call in IF/ID with if_id_pc=8; rrwe=1, pc_src=10, jump_src=0, jump_target=40, kill=1. Later drive pc_src=10, jump_src=1, kill=1.
  - Response: rr_value = 9 after the Call; pc = 9 after the Ret.
- Stall priority:
  - Stimulus: at pc=12, stall=1 together with kill=1, pc_src=01, rrwe=1 for two cycles.
  - Response: pc, if_id_* and rr_value unchanged for both cycles; normal advance once stall=0.
- Wrap-around and async reset:
  - Stimulus: pc=16'hFFFF with pc_src=00, then drop rst_n mid-cycle.
  - Response: pc becomes 0 with if_id_pc = 16'hFFFF; on rst_n low all outputs reach reset values before the next edge.
